// File: rtl/jtkcpu_regs_pkg.sv
// jtkcpu_regs_pkg
// Shared definitions for the KONAMI-2 register file and its PSH/PUL sequencer:
// register-select codes, CC bit positions, the PSH/PUL postbyte bit order,
// the sequencer state type, and the postbyte walk helpers.
package jtkcpu_regs_pkg;

    // opnd0 / writeback register-select codes
    localparam logic [3:0] RSEL_D  = 4'h0;
    localparam logic [3:0] RSEL_X  = 4'h1;
    localparam logic [3:0] RSEL_Y  = 4'h2;
    localparam logic [3:0] RSEL_U  = 4'h3;
    localparam logic [3:0] RSEL_S  = 4'h4;
    localparam logic [3:0] RSEL_A  = 4'h8;
    localparam logic [3:0] RSEL_B  = 4'h9;
    localparam logic [3:0] RSEL_CC = 4'hA;
    localparam logic [3:0] RSEL_DP = 4'hB;

    // CC flag positions that are set by reset
    localparam int CC_I = 4;
    localparam int CC_F = 6;
    localparam logic [7:0] CC_RST_DEF = (8'd1 << CC_F) | (8'd1 << CC_I);

    // PSH/PUL postbyte bit order
    localparam logic [2:0] PB_CC = 3'd0;
    localparam logic [2:0] PB_A  = 3'd1;
    localparam logic [2:0] PB_B  = 3'd2;
    localparam logic [2:0] PB_DP = 3'd3;
    localparam logic [2:0] PB_X  = 3'd4;
    localparam logic [2:0] PB_Y  = 3'd5;
    localparam logic [2:0] PB_US = 3'd6;
    localparam logic [2:0] PB_PC = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUSH = 2'd1,
        ST_PULL = 2'd2,
        ST_DONE = 2'd3
    } stk_state_t;

    // Index of the highest set bit (push walks from bit 7 down)
    function automatic logic [2:0] msb_idx(input logic [7:0] v);
        msb_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) msb_idx = 3'(i);
        end
    endfunction

    // Index of the lowest set bit (pull walks from bit 0 up)
    function automatic logic [2:0] lsb_idx(input logic [7:0] v);
        lsb_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lsb_idx = 3'(i);
        end
    endfunction

endpackage

// File: rtl/jtkcpu_regs_stack.sv
// jtkcpu_regs_stack
// PSH/PUL sequencer: walks the postbyte one byte at a time over a
// request/acknowledge memory port.
// Inputs : clk, rst, cen, start/pul/usr/post command, current register values,
//          PC to push, memory read data and ack.
// Outputs: memory request/write/address/data, pulled PC and its strobe, busy,
//          plus per-ack strobes telling the register file to update the stack
//          pointer (o_ptr_*) and to load a pulled byte (o_ld_*).
module jtkcpu_regs_stack
    import jtkcpu_regs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        i_start,
    input  logic        i_pul,
    input  logic        i_usr,
    input  logic [7:0]  i_post,
    input  logic [15:0] i_pc,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    input  logic [7:0]  i_dp,
    input  logic [7:0]  i_cc,
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic [15:0] i_u,
    input  logic [15:0] i_s,
    input  logic [7:0]  i_din,
    input  logic        i_ack,
    output logic        o_req,
    output logic        o_wr,
    output logic [15:0] o_addr,
    output logic [7:0]  o_dout,
    output logic [15:0] o_pc,
    output logic        o_pc_we,
    output logic        o_busy,
    output logic        o_ptr_we,
    output logic        o_ptr_usr,
    output logic [15:0] o_ptr_val,
    output logic        o_ld_we,
    output logic [2:0]  o_ld_bit,
    output logic        o_ld_hi,
    output logic [7:0]  o_ld_data
);

    stk_state_t  r_state;
    logic [7:0]  r_post;
    logic        r_pul;
    logic        r_usr;
    logic        r_second;   // first byte of a 16-bit register already moved
    logic        r_pcpul;    // this pull includes the PC
    logic [2:0]  r_bit;      // postbyte bit of the byte in flight
    logic        r_hi;       // byte in flight is the high half
    logic        r_req;
    logic        r_wr;
    logic [15:0] r_addr;
    logic [7:0]  r_dout;
    logic [15:0] r_pc;
    logic        r_pc_we;
    logic        r_busy;

    logic [2:0]  w_bit;
    logic        w_hi;
    logic [15:0] w_ptr;
    logic [15:0] w_src16;
    logic [7:0]  w_src8;
    logic [7:0]  w_push_byte;
    logic [7:0]  w_post_clr;
    logic        w_ack;

    assign w_bit      = r_pul ? lsb_idx(r_post) : msb_idx(r_post);
    // Push sends low byte first, pull receives high byte first
    assign w_hi       = w_bit[2] & (r_pul ^ r_second);
    assign w_ptr      = r_usr ? i_u : i_s;
    assign w_post_clr = r_post & ~(8'd1 << r_bit);
    assign w_ack      = cen & r_req & i_ack;

    // Select the byte to push for the next postbyte bit
    always_comb begin
        w_src16 = 16'h0000;
        w_src8  = 8'h00;
        case (w_bit)
            PB_PC:   w_src16 = i_pc;
            PB_US:   w_src16 = r_usr ? i_s : i_u;
            PB_Y:    w_src16 = i_y;
            PB_X:    w_src16 = i_x;
            PB_DP:   w_src8  = i_dp;
            PB_B:    w_src8  = i_b;
            PB_A:    w_src8  = i_a;
            PB_CC:   w_src8  = i_cc;
            default: w_src16 = 16'h0000;
        endcase
        if (w_bit[2]) begin
            w_push_byte = w_hi ? w_src16[15:8] : w_src16[7:0];
        end else begin
            w_push_byte = w_src8;
        end
    end

    // Sequencer FSM, postbyte walk and memory port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_post   <= 8'h00;
            r_pul    <= 1'b0;
            r_usr    <= 1'b0;
            r_second <= 1'b0;
            r_pcpul  <= 1'b0;
            r_bit    <= 3'd0;
            r_hi     <= 1'b0;
            r_req    <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= 16'h0000;
            r_dout   <= 8'h00;
            r_pc     <= 16'h0000;
            r_pc_we  <= 1'b0;
            r_busy   <= 1'b0;
        end else if (cen) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_pul    <= i_pul;
                        r_usr    <= i_usr;
                        r_post   <= i_post;
                        r_second <= 1'b0;
                        r_pcpul  <= i_pul & i_post[7];
                        r_busy   <= 1'b1;
                        if (i_post == 8'h00) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= i_pul ? ST_PULL : ST_PUSH;
                        end
                    end
                end
                ST_PUSH, ST_PULL: begin
                    if (r_req) begin
                        if (i_ack) begin
                            r_req <= 1'b0;
                            if (r_pul && (r_bit == PB_PC)) begin
                                if (r_hi) r_pc[15:8] <= i_din;
                                else      r_pc[7:0]  <= i_din;
                            end
                            if (r_bit[2] && !r_second) begin
                                r_second <= 1'b1;
                            end else begin
                                r_second <= 1'b0;
                                r_post   <= w_post_clr;
                                if (w_post_clr == 8'h00) begin
                                    r_state <= ST_DONE;
                                    r_pc_we <= r_pcpul;
                                end
                            end
                        end
                    end else begin
                        // Push pre-decrements; pull reads at the pointer
                        r_req  <= 1'b1;
                        r_wr   <= ~r_pul;
                        r_bit  <= w_bit;
                        r_hi   <= w_hi;
                        r_addr <= r_pul ? w_ptr : (w_ptr - 16'd1);
                        r_dout <= r_pul ? 8'h00 : w_push_byte;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_pc_we <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req     = r_req;
    assign o_wr      = r_wr;
    assign o_addr    = r_addr;
    assign o_dout    = r_dout;
    assign o_pc      = r_pc;
    assign o_pc_we   = r_pc_we;
    assign o_busy    = r_busy;
    // The in-flight address already holds the decremented pointer for a push
    assign o_ptr_we  = w_ack;
    assign o_ptr_usr = r_usr;
    assign o_ptr_val = r_wr ? r_addr : (r_addr + 16'd1);
    assign o_ld_we   = w_ack & r_pul & (r_bit != PB_PC);
    assign o_ld_bit  = r_bit;
    assign o_ld_hi   = r_hi;
    assign o_ld_data = i_din;

endmodule

// File: rtl/jtkcpu_regs.sv
// jtkcpu_regs
// KONAMI-2 programmer-visible registers A, B (D={A,B}), X, Y, U, S, DP, CC.
// Inputs : clk, rst (sync, active high), cen, rd_sel, ALU writeback
//          (wr_en/wr_sel/rslt, lmul_we/rslt_hi, cc_we/cc_alu), PSH/PUL command
//          (stk_start/pul/usr/post), pc_in, memory stk_din/stk_ack.
// Outputs: opnd0 (combinational read), cc, pc_out/pc_we, memory
//          stk_req/wr/addr/dout, busy.
module jtkcpu_regs
    import jtkcpu_regs_pkg::*;
#(
    parameter logic [7:0] CC_RST = CC_RST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [3:0]  rd_sel,
    output logic [15:0] opnd0,
    output logic [7:0]  cc,
    input  logic        wr_en,
    input  logic [3:0]  wr_sel,
    input  logic [15:0] rslt,
    input  logic [15:0] rslt_hi,
    input  logic        lmul_we,
    input  logic        cc_we,
    input  logic [7:0]  cc_alu,
    input  logic        stk_start,
    input  logic        stk_pul,
    input  logic        stk_usr,
    input  logic [7:0]  stk_post,
    input  logic [15:0] pc_in,
    output logic [15:0] pc_out,
    output logic        pc_we,
    output logic        stk_req,
    output logic        stk_wr,
    output logic [15:0] stk_addr,
    output logic [7:0]  stk_dout,
    input  logic [7:0]  stk_din,
    input  logic        stk_ack,
    output logic        busy
);

    logic [7:0]  r_a, r_b, r_dp, r_cc;
    logic [15:0] r_x, r_y, r_u, r_s;

    logic        w_ptr_we, w_ptr_usr, w_ld_we, w_ld_hi;
    logic [15:0] w_ptr_val;
    logic [2:0]  w_ld_bit;
    logic [7:0]  w_ld_data;

    jtkcpu_regs_stack u_stack (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .i_start   (stk_start),
        .i_pul     (stk_pul),
        .i_usr     (stk_usr),
        .i_post    (stk_post),
        .i_pc      (pc_in),
        .i_a       (r_a),
        .i_b       (r_b),
        .i_dp      (r_dp),
        .i_cc      (r_cc),
        .i_x       (r_x),
        .i_y       (r_y),
        .i_u       (r_u),
        .i_s       (r_s),
        .i_din     (stk_din),
        .i_ack     (stk_ack),
        .o_req     (stk_req),
        .o_wr      (stk_wr),
        .o_addr    (stk_addr),
        .o_dout    (stk_dout),
        .o_pc      (pc_out),
        .o_pc_we   (pc_we),
        .o_busy    (busy),
        .o_ptr_we  (w_ptr_we),
        .o_ptr_usr (w_ptr_usr),
        .o_ptr_val (w_ptr_val),
        .o_ld_we   (w_ld_we),
        .o_ld_bit  (w_ld_bit),
        .o_ld_hi   (w_ld_hi),
        .o_ld_data (w_ld_data)
    );

    // opnd0 read mux: registered state only, 8-bit sources zero-extended
    always_comb begin
        case (rd_sel)
            RSEL_D:  opnd0 = {r_a, r_b};
            RSEL_X:  opnd0 = r_x;
            RSEL_Y:  opnd0 = r_y;
            RSEL_U:  opnd0 = r_u;
            RSEL_S:  opnd0 = r_s;
            RSEL_A:  opnd0 = {8'h00, r_a};
            RSEL_B:  opnd0 = {8'h00, r_b};
            RSEL_CC: opnd0 = {8'h00, r_cc};
            RSEL_DP: opnd0 = {8'h00, r_dp};
            default: opnd0 = 16'h0000;
        endcase
    end

    assign cc = r_cc;

    // Register storage: sequencer updates first, ALU writeback after so it wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a  <= 8'h00;
            r_b  <= 8'h00;
            r_dp <= 8'h00;
            r_cc <= CC_RST;
            r_x  <= 16'h0000;
            r_y  <= 16'h0000;
            r_u  <= 16'h0000;
            r_s  <= 16'h0000;
        end else if (cen) begin
            if (w_ptr_we) begin
                if (w_ptr_usr) r_u <= w_ptr_val;
                else           r_s <= w_ptr_val;
            end
            if (w_ld_we) begin
                case (w_ld_bit)
                    PB_CC: r_cc <= w_ld_data;
                    PB_A:  r_a  <= w_ld_data;
                    PB_B:  r_b  <= w_ld_data;
                    PB_DP: r_dp <= w_ld_data;
                    PB_X: begin
                        if (w_ld_hi) r_x[15:8] <= w_ld_data;
                        else         r_x[7:0]  <= w_ld_data;
                    end
                    PB_Y: begin
                        if (w_ld_hi) r_y[15:8] <= w_ld_data;
                        else         r_y[7:0]  <= w_ld_data;
                    end
                    PB_US: begin
                        // Bit 6 names the other stack pointer
                        if (w_ptr_usr) begin
                            if (w_ld_hi) r_s[15:8] <= w_ld_data;
                            else         r_s[7:0]  <= w_ld_data;
                        end else begin
                            if (w_ld_hi) r_u[15:8] <= w_ld_data;
                            else         r_u[7:0]  <= w_ld_data;
                        end
                    end
                    default: ;
                endcase
            end
            if (lmul_we) begin
                r_x <= rslt;
                r_y <= rslt_hi;
            end else if (wr_en) begin
                case (wr_sel)
                    RSEL_D: begin
                        r_a <= rslt[15:8];
                        r_b <= rslt[7:0];
                    end
                    RSEL_X:  r_x  <= rslt;
                    RSEL_Y:  r_y  <= rslt;
                    RSEL_U:  r_u  <= rslt;
                    RSEL_S:  r_s  <= rslt;
                    RSEL_A:  r_a  <= rslt[7:0];
                    RSEL_B:  r_b  <= rslt[7:0];
                    RSEL_DP: r_dp <= rslt[7:0];
                    default: ;
                endcase
            end
            // An explicit CC write through wr_sel overrides the ALU flags
            if (!lmul_we && wr_en && (wr_sel == RSEL_CC)) begin
                r_cc <= rslt[7:0];
            end else if (cc_we) begin
                r_cc <= cc_alu;
            end
        end
    end

endmodule

// File: tb/tb_jtkcpu_regs.sv
module tb_jtkcpu_regs;

    logic        clk = 1'b0;
    logic        rst, cen;
    logic [3:0]  rd_sel;
    logic [15:0] opnd0;
    logic [7:0]  cc;
    logic        wr_en;
    logic [3:0]  wr_sel;
    logic [15:0] rslt, rslt_hi;
    logic        lmul_we, cc_we;
    logic [7:0]  cc_alu;
    logic        stk_start, stk_pul, stk_usr;
    logic [7:0]  stk_post;
    logic [15:0] pc_in, pc_out;
    logic        pc_we, stk_req, stk_wr;
    logic [15:0] stk_addr;
    logic [7:0]  stk_dout, stk_din;
    logic        stk_ack, busy;

    always #5 clk = ~clk;

    jtkcpu_regs #(.CC_RST(8'h50)) dut (
        .clk(clk), .rst(rst), .cen(cen), .rd_sel(rd_sel), .opnd0(opnd0), .cc(cc),
        .wr_en(wr_en), .wr_sel(wr_sel), .rslt(rslt), .rslt_hi(rslt_hi),
        .lmul_we(lmul_we), .cc_we(cc_we), .cc_alu(cc_alu),
        .stk_start(stk_start), .stk_pul(stk_pul), .stk_usr(stk_usr), .stk_post(stk_post),
        .pc_in(pc_in), .pc_out(pc_out), .pc_we(pc_we),
        .stk_req(stk_req), .stk_wr(stk_wr), .stk_addr(stk_addr), .stk_dout(stk_dout),
        .stk_din(stk_din), .stk_ack(stk_ack), .busy(busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_a, m_b, m_dp, m_cc;
    logic [15:0] m_x, m_y, m_u, m_s;
    logic [7:0]  model_mem [0:65535];
    logic [7:0]  dut_mem   [0:65535];

    typedef struct { logic [15:0] addr; logic wr; logic [7:0] data; } mem_exp_t;
    typedef struct { logic [3:0] sel; logic [15:0] val; logic [7:0] ccv; } obs_exp_t;
    mem_exp_t    mem_q[$];
    obs_exp_t    obs_q[$];
    logic [15:0] pc_q[$];

    function automatic void m_reset();
        m_a = 8'h00; m_b = 8'h00; m_dp = 8'h00; m_cc = 8'h50;
        m_x = 16'h0000; m_y = 16'h0000; m_u = 16'h0000; m_s = 16'h0000;
    endfunction

    function automatic logic [15:0] m_read(input logic [3:0] sel);
        case (sel)
            4'h0: return {m_a, m_b};
            4'h1: return m_x;
            4'h2: return m_y;
            4'h3: return m_u;
            4'h4: return m_s;
            4'h8: return {8'h00, m_a};
            4'h9: return {8'h00, m_b};
            4'hA: return {8'h00, m_cc};
            4'hB: return {8'h00, m_dp};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic void m_wb(input logic we, input logic [3:0] sel, input logic [15:0] r,
                                 input logic [15:0] rh, input logic lm, input logic cw,
                                 input logic [7:0] ca);
        logic cc_by_wr;
        cc_by_wr = !lm && we && (sel == 4'hA);
        if (lm) begin
            m_x = r; m_y = rh;
        end else if (we) begin
            case (sel)
                4'h0: begin m_a = r[15:8]; m_b = r[7:0]; end
                4'h1: m_x = r;
                4'h2: m_y = r;
                4'h3: m_u = r;
                4'h4: m_s = r;
                4'h8: m_a = r[7:0];
                4'h9: m_b = r[7:0];
                4'hA: m_cc = r[7:0];
                4'hB: m_dp = r[7:0];
                default: ;
            endcase
        end
        if (cw && !cc_by_wr) m_cc = ca;
    endfunction

    // Push: every byte goes to --ptr, registers from bit 7 down, low byte first
    function automatic void m_push(input logic usr, input logic [7:0] post, input logic [15:0] pc);
        logic [15:0] p, v;
        p = usr ? m_u : m_s;
        for (int b = 7; b >= 0; b--) begin
            if (post[b]) begin
                case (b)
                    7: v = pc;
                    6: v = usr ? m_s : m_u;
                    5: v = m_y;
                    4: v = m_x;
                    3: v = {8'h00, m_dp};
                    2: v = {8'h00, m_b};
                    1: v = {8'h00, m_a};
                    default: v = {8'h00, m_cc};
                endcase
                p = p - 16'd1;
                mem_q.push_back('{addr: p, wr: 1'b1, data: v[7:0]});
                model_mem[p] = v[7:0];
                if (b >= 4) begin
                    p = p - 16'd1;
                    mem_q.push_back('{addr: p, wr: 1'b1, data: v[15:8]});
                    model_mem[p] = v[15:8];
                end
            end
        end
        if (usr) m_u = p; else m_s = p;
    endfunction

    // Pull: every byte comes from ptr++, registers from bit 0 up, high byte first
    function automatic void m_pull(input logic usr, input logic [7:0] post);
        logic [15:0] p, v;
        p = usr ? m_u : m_s;
        for (int b = 0; b < 8; b++) begin
            if (post[b]) begin
                v = 16'h0000;
                if (b >= 4) begin
                    mem_q.push_back('{addr: p, wr: 1'b0, data: 8'h00});
                    v[15:8] = model_mem[p];
                    p = p + 16'd1;
                end
                mem_q.push_back('{addr: p, wr: 1'b0, data: 8'h00});
                v[7:0] = model_mem[p];
                p = p + 16'd1;
                case (b)
                    0: m_cc = v[7:0];
                    1: m_a  = v[7:0];
                    2: m_b  = v[7:0];
                    3: m_dp = v[7:0];
                    4: m_x  = v;
                    5: m_y  = v;
                    6: if (usr) m_s = v; else m_u = v;
                    default: pc_q.push_back(v);
                endcase
            end
        end
        if (usr) m_u = p; else m_s = p;
    endfunction

    // ---------------- environment ----------------
    logic ack_en = 1'b1;
    logic obs_v  = 1'b0;
    int   ack_cnt = 0;
    int   cen_since = 0;

    // Random clock enable
    initial begin
        cen = 1'b1;
        forever begin
            @(negedge clk);
            cen = ($urandom_range(0, 3) != 0);
        end
    end

    // Acks and cen edges since the last ack/start
    always @(posedge clk) begin
        if (cen && stk_req && stk_ack) ack_cnt++;
        if (cen) begin
            if ((stk_req && stk_ack) || (stk_start && !busy)) cen_since = 0;
            else cen_since++;
        end
    end

    // Memory responder with random latency
    initial begin
        stk_ack = 1'b0;
        stk_din = 8'h00;
        forever begin
            @(negedge clk);
            if (stk_req && !stk_ack && ack_en) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if (stk_wr) dut_mem[stk_addr] = stk_dout;
                else        stk_din = dut_mem[stk_addr];
                stk_ack = 1'b1;
                do @(posedge clk); while (!cen);
                @(negedge clk);
                stk_ack = 1'b0;
            end
        end
    end

    // Monitor: memory requests and pc_we pulses
    mem_exp_t cur_exp;
    logic     prev_req = 1'b0;
    logic     prev_pcwe = 1'b0;
    always @(negedge clk) begin
        if (stk_req && !prev_req) begin
            if (mem_q.size() > 0) begin
                cur_exp = mem_q.pop_front();
                check("mem_addr", stk_addr, cur_exp.addr);
                check("mem_wr", stk_wr, cur_exp.wr);
                if (cur_exp.wr) check("mem_dout", stk_dout, cur_exp.data);
            end else begin
                n_checks++; n_err++;
                $display("FAIL mem_req: unexpected request addr=%h, none pending", stk_addr);
            end
        end else if (stk_req) begin
            check("mem_addr_stable", stk_addr, cur_exp.addr);
            if (cur_exp.wr) check("mem_dout_stable", stk_dout, cur_exp.data);
        end
        prev_req = stk_req;
        if (pc_we && !prev_pcwe) begin
            if (pc_q.size() > 0) begin
                check("pc_out", pc_out, pc_q.pop_front());
            end else begin
                n_checks++; n_err++;
                $display("FAIL pc_we: unexpected pulse pc_out=%h, none pending", pc_out);
            end
        end
        prev_pcwe = pc_we;
    end

    // Monitor: register observations
    obs_exp_t oe;
    always @(posedge clk) begin
        #1;
        if (obs_v) begin
            if (obs_q.size() > 0) begin
                oe = obs_q.pop_front();
                check($sformatf("opnd0[%0h]", oe.sel), opnd0, oe.val);
                check("cc", cc, oe.ccv);
            end else begin
                n_checks++; n_err++;
                $display("FAIL obs: opnd0=%h with no pending expectation", opnd0);
            end
        end
    end

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    task automatic cen_edge();
        do @(posedge clk); while (!cen);
    endtask

    task automatic wb(input logic we, input logic [3:0] sel, input logic [15:0] r,
                      input logic [15:0] rh, input logic lm, input logic cw, input logic [7:0] ca);
        @(negedge clk);
        wr_en = we; wr_sel = sel; rslt = r; rslt_hi = rh; lmul_we = lm; cc_we = cw; cc_alu = ca;
        cen_edge();
        m_wb(we, sel, r, rh, lm, cw, ca);
        @(negedge clk);
        wr_en = 1'b0; lmul_we = 1'b0; cc_we = 1'b0;
    endtask

    task automatic observe(input logic [3:0] sel);
        @(negedge clk);
        rd_sel = sel;
        obs_q.push_back('{sel: sel, val: m_read(sel), ccv: m_cc});
        obs_v = 1'b1;
        @(negedge clk);
        obs_v = 1'b0;
    endtask

    task automatic run_seq(input logic pul, input logic usr, input logic [7:0] post,
                           input logic [15:0] pc);
        int t;
        if (pul) m_pull(usr, post); else m_push(usr, post, pc);
        @(negedge clk);
        stk_start = 1'b1; stk_pul = pul; stk_usr = usr; stk_post = post; pc_in = pc;
        cen_edge();
        @(negedge clk);
        stk_start = 1'b0;
        t = 0;
        while (busy && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            n_checks++; n_err++;
            $display("FAIL seq_timeout: busy still %0d after %0d cycles, expected 0", busy, t);
        end else begin
            check("busy_fall_cens", cen_since, 1);
        end
    endtask

    initial begin
        logic [3:0] sels [10];
        int t, base;
        sels = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB, 4'h5};
        rst = 1'b1; rd_sel = 4'h0; wr_en = 1'b0; wr_sel = 4'h0; rslt = 16'h0; rslt_hi = 16'h0;
        lmul_we = 1'b0; cc_we = 1'b0; cc_alu = 8'h00; stk_start = 1'b0; stk_pul = 1'b0;
        stk_usr = 1'b0; stk_post = 8'h00; pc_in = 16'h0000;
        for (int i = 0; i < 65536; i++) begin
            model_mem[i] = 8'($urandom);
            dut_mem[i]   = model_mem[i];
        end
        m_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_req", stk_req, 0);
        check("rst_pc_we", pc_we, 0);
        check("rst_addr", stk_addr, 0);
        check("rst_cc_port", cc, 8'h50);
        foreach (sels[i]) observe(sels[i]);

        // D write splits into A/B
        wb(1'b1, 4'h0, 16'h1234, 16'h0000, 1'b0, 1'b0, 8'h00);
        observe(4'h8); observe(4'h9); observe(4'h0);

        // LMUL plus simultaneous CC update
        wb(1'b0, 4'h0, 16'hBEEF, 16'hDEAD, 1'b1, 1'b1, 8'h04);
        observe(4'h1); observe(4'h2); observe(4'hA);

        // wr_sel=CC beats cc_we; cc_we acts alongside a non-CC write
        wb(1'b1, 4'hA, 16'h00A5, 16'h0000, 1'b0, 1'b1, 8'h3C);
        observe(4'hA);
        wb(1'b1, 4'hB, 16'h0077, 16'h0000, 1'b0, 1'b1, 8'h81);
        observe(4'hB);

        // Push PC, B, A onto S=0100
        wb(1'b1, 4'h4, 16'h0100, 16'h0000, 1'b0, 1'b0, 8'h00);
        run_seq(1'b0, 1'b0, 8'h86, 16'hABCD);
        observe(4'h4);

        // Pull CC and PC from U=FFFF, pointer wraps
        wb(1'b1, 4'h3, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 8'h00);
        model_mem[16'hFFFF] = 8'h12; dut_mem[16'hFFFF] = 8'h12;
        model_mem[16'h0000] = 8'h34; dut_mem[16'h0000] = 8'h34;
        model_mem[16'h0001] = 8'h56; dut_mem[16'h0001] = 8'h56;
        run_seq(1'b1, 1'b1, 8'h81, 16'h0000);
        observe(4'hA); observe(4'h3);

        // Empty postbyte
        run_seq(1'b0, 1'b1, 8'h00, 16'h1111);

        // Reset in the middle of a push, after two acks
        wb(1'b1, 4'h4, 16'h0200, 16'h0000, 1'b0, 1'b0, 8'h00);
        base = ack_cnt;
        @(negedge clk);
        stk_start = 1'b1; stk_pul = 1'b0; stk_usr = 1'b0; stk_post = 8'h86; pc_in = 16'h5A5A;
        m_push(1'b0, 8'h86, 16'h5A5A);
        cen_edge();
        @(negedge clk);
        stk_start = 1'b0;
        t = 0;
        while (ack_cnt < base + 2 && t < 2000) begin @(negedge clk); t++; end
        ack_en = 1'b0;
        t = 0;
        while (!stk_req && t < 200) begin @(negedge clk); t++; end
        check("mid_push_req_up", stk_req, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_abort_req", stk_req, 0);
        check("rst_abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        mem_q.delete();
        m_reset();
        ack_en = 1'b1;
        observe(4'h4); observe(4'hA);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    wb(1'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
                       ($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom));
                    observe(4'($urandom));
                end
                2: begin
                    observe(sels[$urandom_range(0, 9)]);
                    observe(sels[$urandom_range(0, 9)]);
                end
                default: begin
                    run_seq(1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom));
                    observe(sels[$urandom_range(0, 4)]);
                end
            endcase
        end
        foreach (sels[i]) observe(sels[i]);

        repeat (4) @(negedge clk);
        check("mem_q_drained", mem_q.size(), 0);
        check("pc_q_drained", pc_q.size(), 0);
        check("obs_q_drained", obs_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
